decimal_to_bcd: RTL and testbench

Registered decimal-key-to-BCD encoder. Takes a 10-line decimal input, where line i asserted means digit i, and produces the 4-bit BCD code of the asserted digit. It also flags when no line or more than one line is asserted. It sits between keypad/selector logic and BCD display or arithmetic stages.

---
 rtl/decimal_to_bcd.sv | 54 +++++
 tb/tb_decimal_to_bcd.sv | 120 ++++++++++++
 2 files changed

// File: rtl/decimal_to_bcd.sv
// Purpose: encodes a 10-line decimal key input to a 4-bit BCD code, flagging empty and multi-hot inputs.
// Latency: 1 cycle; D is sampled on each rising clk edge and the outputs are registered.
// Backpressure: none; a new sample is taken every cycle and the outputs hold between edges.
module decimal_to_bcd #(
   parameter bit HIGH_PRIORITY = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] D,
   output logic [3:0] BCD,
   output logic       valid,
   output logic       err
);

   logic [3:0] enc_code;
   logic       any_hot;
   logic       multi_hot;

   // Priority-encode the asserted line; the scan order decides which index wins on multi-hot input.
   always_comb begin
      enc_code = 4'd0;
      if (HIGH_PRIORITY) begin
         // Ascending scan: the last hit is the highest set index.
         for (int i = 0; i < 10; i++) begin
            if (D[i]) enc_code = 4'(i);
         end
      end else begin
         // Descending scan: the last hit is the lowest set index.
         for (int i = 9; i >= 0; i--) begin
            if (D[i]) enc_code = 4'(i);
         end
      end
   end

   // Clearing the lowest set bit leaves something only when two or more lines are high.
   always_comb begin
      any_hot   = |D;
      multi_hot = |(D & (D - 10'd1));
   end

   // Register the encoded result; reset takes priority over the D sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         BCD   <= 4'd0;
         valid <= 1'b0;
         err   <= 1'b0;
      end else begin
         BCD   <= enc_code;
         valid <= any_hot;
         err   <= multi_hot;
      end
   end

endmodule

// File: tb/tb_decimal_to_bcd.sv
// Directed bench for decimal_to_bcd: both priority settings are instantiated side by side on the same inputs.
module tb_decimal_to_bcd;

   logic       clk;
   logic       rst;
   logic [9:0] D;
   logic [3:0] bcd_hi, bcd_lo;
   logic       valid_hi, valid_lo;
   logic       err_hi, err_lo;

   int errors = 0;
   int checks = 0;

   decimal_to_bcd #(.HIGH_PRIORITY(1'b1)) dut_hi (
      .clk(clk), .rst(rst), .D(D), .BCD(bcd_hi), .valid(valid_hi), .err(err_hi)
   );

   decimal_to_bcd #(.HIGH_PRIORITY(1'b0)) dut_lo (
      .clk(clk), .rst(rst), .D(D), .BCD(bcd_lo), .valid(valid_lo), .err(err_lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Check both instances: BCD per priority setting, shared valid/err expectation.
   task automatic chk_all(input string tag, input logic [3:0] exp_hi, input logic [3:0] exp_lo,
                          input logic exp_valid, input logic exp_err);
      chk({tag, "_bcd_hi"}, bcd_hi, exp_hi);
      chk({tag, "_bcd_lo"}, bcd_lo, exp_lo);
      chk({tag, "_valid_hi"}, {3'b000, valid_hi}, {3'b000, exp_valid});
      chk({tag, "_valid_lo"}, {3'b000, valid_lo}, {3'b000, exp_valid});
      chk({tag, "_err_hi"}, {3'b000, err_hi}, {3'b000, exp_err});
      chk({tag, "_err_lo"}, {3'b000, err_lo}, {3'b000, exp_err});
   endtask

   // Advance past the next rising edge and settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] exp_digit;
      rst = 1'b1;
      D   = 10'b1111111111;

      // Reset held for two edges with every line high.
      tick();
      chk_all("reset1", 4'b0000, 4'b0000, 1'b0, 1'b0);
      tick();
      chk_all("reset2", 4'b0000, 4'b0000, 1'b0, 1'b0);

      // One-hot sweep: every digit line alone.
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         D = 10'b0000000001 << i;
         exp_digit = 4'(i);
         tick();
         chk_all($sformatf("onehot%0d", i), exp_digit, exp_digit, 1'b1, 1'b0);
      end

      // Zero input.
      D = 10'b0000000000;
      tick();
      chk_all("zero", 4'b0000, 4'b0000, 1'b0, 1'b0);

      // Multi-hot: bits 5 and 2.
      D = 10'b0000100100;
      tick();
      chk_all("multi_5_2", 4'b0101, 4'b0010, 1'b1, 1'b1);

      // Multi-hot: extreme bits 9 and 0.
      D = 10'b1000000001;
      tick();
      chk_all("multi_9_0", 4'b1001, 4'b0000, 1'b1, 1'b1);

      // Multi-hot: adjacent bits 7 and 6.
      D = 10'b0011000000;
      tick();
      chk_all("multi_7_6", 4'b0111, 4'b0110, 1'b1, 1'b1);

      // Multi-hot: all lines.
      D = 10'b1111111111;
      tick();
      chk_all("multi_all", 4'b1001, 4'b0000, 1'b1, 1'b1);

      // Latency: output must not follow D until the next edge.
      D = 10'b0000001000;
      tick();
      chk_all("lat_d3", 4'b0011, 4'b0011, 1'b1, 1'b0);
      D = 10'b0010000000;
      #2;
      chk_all("lat_hold", 4'b0011, 4'b0011, 1'b1, 1'b0);
      tick();
      chk_all("lat_d7", 4'b0111, 4'b0111, 1'b1, 1'b0);

      // Reset mid-stream with digit 9 present.
      D = 10'b1000000000;
      tick();
      chk_all("pre_rst_d9", 4'b1001, 4'b1001, 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      chk_all("mid_rst", 4'b0000, 4'b0000, 1'b0, 1'b0);
      rst = 1'b0;
      tick();
      chk_all("post_rst_d9", 4'b1001, 4'b1001, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
